// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result bundle for the digit-serial adder
// Ovf exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             Sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             Ovf;
`endif

  modport master (
    output start, Sub, A, B, Cin,
`ifdef SERIAL_ADDER_OVF_EN
    input  Ovf,
`endif
    input  busy, done, Sum, Cout
  );

  modport slave (
    input  start, Sub, A, B, Cin,
`ifdef SERIAL_ADDER_OVF_EN
    output Ovf,
`endif
    output busy, done, Sum, Cout
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder/subtractor, DIGIT bits per clock
// Optional signed-overflow output under SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept, busy_c, done_c;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt, sum_q;
  logic             carry, cout_q;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] dsum;
  logic             dcarry;
  logic             last;

  assign {dcarry, dsum} = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                        + (DIGIT+1)'(carry);
  assign last    = (cnt == CW'(STEPS - 1));
  // New digit enters at the MSB end so the word is aligned after STEPS shifts
  assign res_nxt = WIDTH'({dsum, res_sh} >> DIGIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done_c = 1'b1;
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B once here, seed the carry with 1
      a_sh   <= bus.A;
      b_sh   <= bus.B ^ {WIDTH{bus.Sub}};
      carry  <= bus.Sub | bus.Cin;
      res_sh <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      res_sh <= res_nxt;
      carry  <= dcarry;
      cnt    <= cnt + CW'(1);
      if (last) begin
        sum_q  <= res_nxt;
        cout_q <= dcarry;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;
  logic msb_cin;

  // Carry into the word MSB recovered from its sum bit: s = a ^ b ^ cin
  assign msb_cin = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ dsum[DIGIT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     ovf_q <= 1'b0;
    else if (state == RUN && last)  ovf_q <= msb_cin ^ dcarry;
  end

  assign bus.Ovf = ovf_q;
`endif

  assign bus.busy = busy_c;
  assign bus.done = done_c;
  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed checks for serial_adder, DIGIT=1 and DIGIT=4
// Ovf checks compile in when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if1 ();
  serial_adder_if #(.WIDTH(8)) if4 ();

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ovf;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    if1.A = a; if1.B = b; if1.Cin = cin; if1.Sub = sub;
    if4.A = a; if4.B = b; if4.Cin = cin; if4.Sub = sub;
  endtask

  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic sub);
    logic [7:0] bb;
    logic       ci;
    logic [8:0] r;
    logic       ov;
    bb = sub ? ~b : b;
    ci = sub ? 1'b1 : cin;
    r  = {1'b0, a} + {1'b0, bb} + 9'(ci);
    ov = (a[7] == bb[7]) && (r[7] != a[7]);
    return {ov, r};
  endfunction

  // Start both DUTs together and check latency, busy/done shape and result
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, input logic [7:0] es, input logic ec,
                        input logic eo, input string nm);
    int nb1, nb4, nd1, nd4, lat1, lat4;
    @(negedge clk);
    drive(a, b, cin, sub);
    if1.start = 1'b1; if4.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0; if4.start = 1'b0;
    drive(~a, ~b, ~cin, ~sub);
    nb1 = int'(if1.busy); nb4 = int'(if4.busy);
    nd1 = 0; nd4 = 0; lat1 = -1; lat4 = -1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      nb1 += int'(if1.busy);
      nb4 += int'(if4.busy);
      if (if1.done) begin nd1++; if (lat1 < 0) lat1 = c; end
      if (if4.done) begin nd4++; if (lat4 < 0) lat4 = c; end
    end
    chk({nm, " d1 latency"}, lat1, 8);
    chk({nm, " d1 busy cycles"}, nb1, 8);
    chk({nm, " d1 done pulses"}, nd1, 1);
    chk({nm, " d1 Sum"}, 32'(if1.Sum), 32'(es));
    chk({nm, " d1 Cout"}, 32'(if1.Cout), 32'(ec));
    chk({nm, " d4 latency"}, lat4, 2);
    chk({nm, " d4 busy cycles"}, nb4, 2);
    chk({nm, " d4 Sum"}, 32'(if4.Sum), 32'(es));
    chk({nm, " d4 Cout"}, 32'(if4.Cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    chk({nm, " d1 Ovf"}, 32'(if1.Ovf), 32'(eo));
    chk({nm, " d4 Ovf"}, 32'(if4.Ovf), 32'(eo));
`else
    if (eo === 1'bx) chk({nm, " ovf expectation known"}, 32'(eo), 0);
`endif
  endtask

  task automatic wait_done1(output int lat);
    lat = -1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (if1.done) lat = c;
    end
  endtask

  initial begin
    int lat, nd;
    logic [9:0] m;
    logic [7:0] sa, sb;

    vecs[0]  = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1]  = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[2]  = '{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0};
    vecs[3]  = '{8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[4]  = '{8'hF0, 8'h10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[5]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[7]  = '{8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0};
    vecs[8]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[10] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[11] = '{8'h20, 8'h05, 1'b1, 1'b1, 8'h1B, 1'b1, 1'b0};

    if1.start = 1'b0; if4.start = 1'b0;
    drive(8'h00, 8'h00, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(if1.busy), 0);
    chk("reset done", 32'(if1.done), 0);
    chk("reset Sum", 32'(if1.Sum), 0);
    chk("reset Cout", 32'(if1.Cout), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset idle busy", 32'(if1.busy), 0);

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
             vecs[i].s, vecs[i].co, vecs[i].ovf, $sformatf("vec%0d", i));

    // Boundary-heavy grid against the arithmetic model
    for (int ai = 0; ai < 6; ai++)
      for (int bi = 0; bi < 4; bi++)
        for (int k = 0; k < 4; k++) begin
          sa = 8'(ai * 51);
          sb = 8'(bi * 85);
          m  = model(sa, sb, k[0], k[1]);
          run_op(sa, sb, k[0], k[1], m[7:0], m[8], m[9],
                 $sformatf("grid %h %h c%0d s%0d", sa, sb, k[0], k[1]));
        end

    // Back-to-back: second start presented during the done cycle
    @(negedge clk);
    drive(8'hFF, 8'h01, 1'b1, 1'b0);
    if1.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0;
    wait_done1(lat);
    chk("b2b first latency", lat, 8);
    chk("b2b first Sum", 32'(if1.Sum), 32'h01);
    chk("b2b first Cout", 32'(if1.Cout), 1);
    drive(8'h10, 8'h01, 1'b0, 1'b1);
    if1.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0;
    chk("b2b accepted busy", 32'(if1.busy), 1);
    chk("b2b accepted done", 32'(if1.done), 0);
    wait_done1(lat);
    chk("b2b second latency", lat, 8);
    chk("b2b second Sum", 32'(if1.Sum), 32'h0F);
    chk("b2b second Cout", 32'(if1.Cout), 1);
    @(posedge clk); #1;

    // start while busy must be ignored
    @(negedge clk);
    drive(8'h01, 8'h02, 1'b0, 1'b1);
    if1.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0;
    lat = -1; nd = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 3) begin drive(8'h55, 8'h11, 1'b0, 1'b0); if1.start = 1'b1; end
      if (c == 4) if1.start = 1'b0;
      @(posedge clk); #1;
      if (if1.done) begin nd++; if (lat < 0) lat = c; end
    end
    chk("ignore latency", lat, 8);
    chk("ignore done pulses", nd, 1);
    chk("ignore Sum", 32'(if1.Sum), 32'hFF);
    chk("ignore Cout", 32'(if1.Cout), 0);

    // Reset mid-computation
    @(negedge clk);
    drive(8'h5A, 8'h3C, 1'b0, 1'b0);
    if1.start = 1'b1; if4.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0; if4.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset busy", 32'(if1.busy), 0);
    chk("midreset Sum", 32'(if1.Sum), 0);
    chk("midreset Cout", 32'(if1.Cout), 0);
    chk("midreset d4 Sum", 32'(if4.Sum), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      nd += int'(if1.done) + int'(if4.done);
    end
    chk("midreset no done", nd, 0);
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
